// File: rtl/l2_wb_line_responder.sv
// l2_wb_line_responder
// Wishbone slave that terminates the L1->L2 master port of the cache
// interconnect. It keeps one 128-bit write-back line buffer. A request that
// hits is answered from the buffer. A miss first writes back the dirty line if
// there is one, then fills from physical memory. A full-line write needs no
// fill and is merged directly.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   CYC, STB, WE    wishbone cycle, strobe, write enable
//   SEL, ADR, DAT_M byte enables, byte address (low offset bits ignored), write line
//   DAT_S, ACK, RTY read line, single-cycle registered ack, retry (always 0)
//   pmem_*          physical memory read/write/resp handshake, line-aligned address
module l2_wb_line_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    CYC,
  input  logic                    STB,
  input  logic                    WE,
  input  logic [LINE_WIDTH/8-1:0] SEL,
  input  logic [ADDR_WIDTH-1:0]   ADR,
  input  logic [LINE_WIDTH-1:0]   DAT_M,
  output logic [LINE_WIDTH-1:0]   DAT_S,
  output logic                    ACK,
  output logic                    RTY,
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic [ADDR_WIDTH-1:0]   pmem_address,
  output logic [LINE_WIDTH-1:0]   pmem_wdata,
  input  logic [LINE_WIDTH-1:0]   pmem_rdata,
  input  logic                    pmem_resp
);

  localparam int SEL_W = LINE_WIDTH / 8;
  localparam int OFF_W = $clog2(SEL_W);
  localparam int TAG_W = ADDR_WIDTH - OFF_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITEBACK,
    S_FILL,
    S_RESPOND,
    S_ACK,
    S_COOLDOWN
  } state_t;

  state_t                 state;

  // Line buffer
  logic [LINE_WIDTH-1:0]  line_buf;
  logic [TAG_W-1:0]       line_tag;
  logic                   line_valid;
  logic                   line_dirty;

  // Latched request
  logic [TAG_W-1:0]       req_tag;
  logic                   req_we;
  logic [SEL_W-1:0]       req_sel;
  logic [LINE_WIDTH-1:0]  req_data;
  // Cleared once the master drops CYC mid-request; such a request gets no ACK.
  logic                   req_live;

  logic [TAG_W-1:0]       adr_tag;
  logic                   req_full;
  logic                   live_now;

  assign adr_tag  = ADR[ADDR_WIDTH-1:OFF_W];
  assign req_full = req_we && (req_sel == {SEL_W{1'b1}});
  assign live_now = req_live && CYC;
  assign RTY      = 1'b0;

  function automatic logic [LINE_WIDTH-1:0] merge_bytes(
    input logic [LINE_WIDTH-1:0] old_line,
    input logic [LINE_WIDTH-1:0] new_line,
    input logic [SEL_W-1:0]      sel
  );
    logic [LINE_WIDTH-1:0] res;
    res = old_line;
    for (int i = 0; i < SEL_W; i++) begin
      if (sel[i]) res[i*8 +: 8] = new_line[i*8 +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ACK          <= 1'b0;
      DAT_S        <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      line_valid   <= 1'b0;
      line_dirty   <= 1'b0;
      req_live     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (CYC && STB) begin
            req_tag  <= adr_tag;
            req_we   <= WE;
            req_sel  <= SEL;
            req_data <= DAT_M;
            req_live <= 1'b1;
            if (line_valid && (line_tag == adr_tag)) begin
              state <= S_RESPOND;
            end else if (line_valid && line_dirty) begin
              state        <= S_WRITEBACK;
              pmem_write   <= 1'b1;
              pmem_address <= {line_tag, {OFF_W{1'b0}}};
              pmem_wdata   <= line_buf;
            end else if (WE && (SEL == {SEL_W{1'b1}})) begin
              // Whole line is overwritten, so the old contents are never needed.
              state <= S_RESPOND;
            end else begin
              state        <= S_FILL;
              pmem_read    <= 1'b1;
              pmem_address <= {adr_tag, {OFF_W{1'b0}}};
            end
          end
        end

        S_WRITEBACK: begin
          if (!CYC) req_live <= 1'b0;
          if (pmem_resp) begin
            pmem_write <= 1'b0;
            line_dirty <= 1'b0;
            if (!live_now) begin
              state <= S_IDLE;
            end else if (req_full) begin
              state <= S_RESPOND;
            end else begin
              // Read strobe rises on the same edge the write strobe falls.
              state        <= S_FILL;
              pmem_read    <= 1'b1;
              pmem_address <= {req_tag, {OFF_W{1'b0}}};
            end
          end
        end

        S_FILL: begin
          if (!CYC) req_live <= 1'b0;
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            line_buf   <= pmem_rdata;
            line_tag   <= req_tag;
            line_valid <= 1'b1;
            line_dirty <= 1'b0;
            state      <= live_now ? S_RESPOND : S_IDLE;
          end
        end

        S_RESPOND: begin
          // The buffer update happens even if the master has given up.
          if (req_we) begin
            line_buf   <= merge_bytes(line_buf, req_data, req_sel);
            line_tag   <= req_tag;
            line_valid <= 1'b1;
            line_dirty <= 1'b1;
          end
          if (live_now) begin
            if (!req_we) DAT_S <= line_buf;
            ACK   <= 1'b1;
            state <= S_ACK;
          end else begin
            state <= S_IDLE;
          end
        end

        S_ACK: begin
          ACK   <= 1'b0;
          state <= S_COOLDOWN;
        end

        // The master is still dropping its held strobe; ignore it for one cycle.
        S_COOLDOWN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_wb_line_responder.sv
// Testbench for l2_wb_line_responder: directed requests with a scoreboard.
// The stimulus pushes expected ACK responses and expected pmem transactions into
// queues. A monitor compares ACK/DAT_S, and a memory model compares and answers
// pmem requests.
module tb_l2_wb_line_responder;

  logic         clk;
  logic         rst;
  logic         CYC;
  logic         STB;
  logic         WE;
  logic [15:0]  SEL;
  logic [15:0]  ADR;
  logic [127:0] DAT_M;
  logic [127:0] DAT_S;
  logic         ACK;
  logic         RTY;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  l2_wb_line_responder #(
    .ADDR_WIDTH(16),
    .LINE_WIDTH(128)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .CYC         (CYC),
    .STB         (STB),
    .WE          (WE),
    .SEL         (SEL),
    .ADR         (ADR),
    .DAT_M       (DAT_M),
    .DAT_S       (DAT_S),
    .ACK         (ACK),
    .RTY         (RTY),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    int           delay;
    bit           no_resp;
  } pm_t;

  typedef struct {
    bit           rd;
    logic [127:0] data;
  } ack_t;

  pm_t  pq[$];
  ack_t ackq[$];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] DM_BEEF = {{14{8'h11}}, 16'hBEEF};
  localparam logic [127:0] M1      = {{14{8'hA5}}, 16'hBEEF};
  localparam logic [127:0] R2      = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] W3      = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] R4      = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] R5      = 128'h55555555_55555555_AAAAAAAA_AAAAAAAA;
  localparam logic [127:0] R6      = 128'h66666666_77777777_88888888_99999999;
  localparam logic [127:0] R7      = 128'h0F0F0F0F_F0F0F0F0_13579BDF_2468ACE0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic push_pm(input logic wr, input logic [15:0] addr, input logic [127:0] wdata,
                         input logic [127:0] rdata, input int delay, input bit no_resp);
    pm_t e;
    e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    e.delay = delay; e.no_resp = no_resp;
    pq.push_back(e);
  endtask

  // Issue one request, hold it until ACK, then let the DUT return to IDLE.
  task automatic do_req(input logic we, input logic [15:0] sel, input logic [15:0] adr,
                        input logic [127:0] dm, input logic [127:0] exp_rd, input int exp_lat);
    ack_t a;
    int   n;
    a.rd = !we;
    a.data = exp_rd;
    ackq.push_back(a);
    CYC = 1'b1; STB = 1'b1; WE = we; SEL = sel; ADR = adr; DAT_M = dm;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ACK && n < 100);
    check("ack_latency", n, exp_lat);
    CYC = 1'b0; STB = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Memory model: checks each new pmem request against the queue and answers it.
  initial begin : pmem_model
    pm_t e;
    bit  skip;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    skip = 1'b0;
    forever begin
      if (!skip) @(negedge clk);
      skip = 1'b0;
      if (!rst && (pmem_read === 1'b1 || pmem_write === 1'b1)) begin
        check("pmem_exclusive", pmem_read & pmem_write, 0);
        if (pq.size() == 0) begin
          fail_now("pmem_unexpected_request");
          for (int i = 0; i < 100 && (pmem_read || pmem_write); i++) @(negedge clk);
          continue;
        end
        e = pq.pop_front();
        check("pmem_op_is_write", pmem_write, e.wr);
        check("pmem_address", pmem_address, e.addr);
        if (e.wr) check("pmem_wdata", pmem_wdata, e.wdata);
        if (e.no_resp) begin
          for (int i = 0; i < 100 && (pmem_read || pmem_write); i++) @(negedge clk);
          continue;
        end
        repeat (e.delay) @(negedge clk);
        pmem_rdata = e.rdata;
        pmem_resp  = 1'b1;
        @(negedge clk);
        pmem_resp  = 1'b0;
        check("pmem_strobe_drop", e.wr ? pmem_write : pmem_read, 0);
        skip = 1'b1;
      end
    end
  end

  // ACK monitor: pops the expected response on every ACK.
  initial begin : ack_monitor
    ack_t a;
    logic prev_ack;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ACK === 1'b1) begin
        check("ack_single_cycle", prev_ack, 0);
        if (ackq.size() == 0) begin
          fail_now("ack_unexpected");
        end else begin
          a = ackq.pop_front();
          if (a.rd) check("dat_s", DAT_S, a.data);
        end
      end
      prev_ack = ACK;
    end
  end

  initial begin : stimulus
    rst = 1'b1; CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    SEL = '0; ADR = '0; DAT_M = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", ACK, 0);
    check("rst_rty", RTY, 0);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_dat_s", DAT_S, 0);
    check("rst_pmem_address", pmem_address, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Clean miss: fill 0x0040
    push_pm(1'b0, 16'h0040, '0, LINE_A5, 2, 1'b0);
    do_req(1'b0, 16'hFFFF, 16'h0040, '0, LINE_A5, 5);
    // Hit, same tag
    do_req(1'b0, 16'hFFFF, 16'h0048, '0, LINE_A5, 2);
    check("dat_s_retained", DAT_S, LINE_A5);
    // Partial write hit, then read back the merge
    do_req(1'b1, 16'h0003, 16'h0040, DM_BEEF, '0, 2);
    do_req(1'b0, 16'hFFFF, 16'h0040, '0, M1, 2);
    // Dirty miss: writeback 0x0040, fill 0x1230
    push_pm(1'b1, 16'h0040, M1, '0, 1, 1'b0);
    push_pm(1'b0, 16'h1230, '0, R2, 0, 1'b0);
    do_req(1'b0, 16'hFFFF, 16'h1230, '0, R2, 5);
    // Full-line write on a clean miss: no fill
    do_req(1'b1, 16'hFFFF, 16'h2000, W3, '0, 2);
    // Following miss writes back 0x2000
    push_pm(1'b1, 16'h2000, W3, '0, 0, 1'b0);
    push_pm(1'b0, 16'h3000, '0, R4, 1, 1'b0);
    do_req(1'b0, 16'hFFFF, 16'h3000, '0, R4, 5);
    // SEL=0 write marks the line dirty, data unchanged
    do_req(1'b1, 16'h0000, 16'h3000, {128{1'b1}}, '0, 2);
    push_pm(1'b1, 16'h3000, R4, '0, 0, 1'b0);
    push_pm(1'b0, 16'h4000, '0, R5, 0, 1'b0);
    do_req(1'b0, 16'hFFFF, 16'h4000, '0, R5, 4);

    // Reset in the middle of a fill
    push_pm(1'b0, 16'h5000, '0, '0, 0, 1'b1);
    CYC = 1'b1; STB = 1'b1; WE = 1'b0; SEL = 16'hFFFF; ADR = 16'h5000;
    repeat (3) @(negedge clk);
    check("fill_active", pmem_read, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pmem_read", pmem_read, 0);
    check("rst_mid_ack", ACK, 0);
    rst = 1'b0; CYC = 1'b0; STB = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_no_ack", ACK, 0);
    // Line invalidated: the old tag must fill again
    push_pm(1'b0, 16'h4000, '0, R6, 0, 1'b0);
    do_req(1'b0, 16'hFFFF, 16'h4000, '0, R6, 3);
    push_pm(1'b0, 16'h5000, '0, R7, 1, 1'b0);
    do_req(1'b0, 16'hFFFF, 16'h5000, '0, R7, 4);
    do_req(1'b0, 16'hFFFF, 16'h5008, '0, R7, 2);
    do_req(1'b0, 16'hFFFF, 16'h500C, '0, R7, 2);

    repeat (4) @(negedge clk);
    check("dat_s_hold", DAT_S, R7);
    check("rty_zero", RTY, 0);
    check("pmem_queue_empty", pq.size(), 0);
    check("ack_queue_empty", ackq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_wb_line_responder.md
Name: l2_wb_line_responder

Overview:
- Wishbone slave that terminates the L1→L2 master port driven by the cache interconnect.
- Holds one write-back 128-bit line buffer, answering single-line read/write requests with a registered ACK.
- On miss it writes back the dirty line if needed, then fills from physical memory over the standard pmem read/write/resp handshake.
- Sits between the interconnect's L2-side master and physical memory; it is the responder counterpart of the interconnect.

Parameters:
ADDR_WIDTH, 16, byte address width of ADR and pmem_address
LINE_WIDTH, 128, line width in bits; SEL width = LINE_WIDTH/8

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
CYC  input  1  wishbone bus cycle
STB  input  1  wishbone strobe
WE  input  1  1 = write, 0 = read
SEL  input  16  byte enables for DAT_M (bit i → byte i)
ADR  input  16  byte address; bits [3:0] ignored, tag = ADR[15:4]
DAT_M  input  128  write line
DAT_S  output  128  read line, valid while ACK=1
ACK  output  1  single-cycle registered acknowledge
RTY  output  1  retry; tied 0
pmem_read  output  1  memory read request
pmem_write  output  1  memory write request
pmem_address  output  16  line-aligned address ([3:0]=0)
pmem_wdata  output  128  writeback line
pmem_rdata  input  128  fill line
pmem_resp  input  1  memory completion pulse

Behaviour:
- Reset (sync, rst=1 at edge): ACK, RTY, pmem_read, pmem_write = 0; DAT_S, pmem_address, pmem_wdata = 0; valid = 0, dirty = 0; state = IDLE.
- Reset mid-transaction aborts pmem strobes at that edge. Dirty data is discarded and no ACK is issued.
- IDLE: on CYC&STB, latch ADR/WE/SEL/DAT_M.
  - Hit = valid && tag==ADR[15:4].
  - Hit → RESPOND.
  - Miss with valid&&dirty → WRITEBACK.
  - Miss otherwise → FILL, or RESPOND directly if WE && SEL==16'hFFFF (full-line write needs no fill).
- WRITEBACK: pmem_write=1, pmem_address={old tag,4'h0}, pmem_wdata=buffer; held until pmem_resp.
  - On resp: dirty=0, then go to FILL, or RESPOND if full-line write.
- FILL: pmem_read=1, pmem_address={req tag,4'h0}; held until pmem_resp.
  - On resp: buffer=pmem_rdata, tag=req tag, valid=1, dirty=0 → RESPOND.
- pmem strobes are never both high. They drop in the cycle after pmem_resp is sampled.
- RESPOND (one cycle):
  - Read: DAT_S ← buffer.
  - Write: buffer byte i ← DAT_M byte i where SEL[i]=1; tag=req tag; valid=1; dirty=1.
  - ACK ← 1 registered, so ACK is visible the following cycle.
  - If CYC deasserted at RESPOND, no ACK; the buffer update still occurs.
- ACK state: ACK=1 for exactly one cycle, DAT_S stable → COOLDOWN.
- COOLDOWN: ACK=0; STB ignored this cycle (master is dropping its held strobe) → IDLE.
- Latency, request sampled at cycle 0:
  - Hit: ACK at cycle 2.
  - Clean miss: ACK = fill cycles + 3.
  - Dirty miss: adds the writeback cycles.
  - Back-to-back hit requests: one per 4 cycles.
- CYC drop during WRITEBACK/FILL: the pmem transaction runs to resp and the buffer is updated as normal. No ACK; return to IDLE.
- WE=1 with SEL=0: treated as a write; marks the line dirty with data unchanged.
- DAT_S retains its last read value outside ACK. RTY is constant 0.

Test Plan:
- Reset then read ADR=16'h0040 → pmem_read with pmem_address=16'h0040; pmem_resp with rdata=128'hA5..A5 → ACK one cycle, DAT_S=128'hA5..A5, no pmem_write.
- Repeat read 16'h0048 (same tag) → no pmem activity; ACK exactly 2 cycles after STB sampled.
- Write 16'h0040, SEL=16'h0003, DAT_M low bytes 16'hBEEF → ACK. Read 16'h0040 → bytes[1:0]=16'hBEEF, rest A5.
- Then read 16'h1230:
  - pmem_write first, address 16'h0040, wdata = merged line.
  - After resp, pmem_read at 16'h1230.
  - ACK with the fill data.
- Full-line write to 16'h2000, SEL=16'hFFFF, while the buffer is clean → no pmem_read, ACK at cycle 2, line dirty. A following miss writes back 16'h2000.
- rst=1 during FILL → pmem_read=0 next cycle, no ACK, valid=0. Next read re-issues the fill.
